// File: rtl/frame_receiver.sv
// Ethernet header parser/filter: matches destination and EtherType, captures source/type/length, keeps statistics.
// Optional FRAME_RECEIVER_PROMISC_EN skips the destination match; results appear 1 cycle after the MAC status cycle.
module frame_receiver #(
    parameter logic [47:0] MAC_LOCAL_ADDR  = 48'h004e46324301,
    parameter logic [15:0] ETH_TYPE_FILTER = 16'h0800,
    parameter int          STATUS_TIMEOUT  = 16
) (
    input  logic        rx_clk,
    input  logic        reset,
    output logic        conf_rx_en,
    output logic        conf_rx_jumbo_en,
    output logic        conf_rx_no_chk_crc,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_good_frame,
    input  logic        mac_rx_bad_frame,
    output logic        frame_valid,
    output logic [47:0] rx_src_addr,
    output logic [15:0] rx_eth_type,
    output logic [13:0] rx_payload_len,
    output logic [15:0] good_count,
    output logic [15:0] bad_count,
    output logic [15:0] drop_count
);

    typedef enum logic [2:0] {
        IDLE,
        MAC_DST,
        MAC_SRC,
        ETH_TYPE,
        DATA,
        WAIT_STATUS
    } state_t;

`ifdef FRAME_RECEIVER_PROMISC_EN
    localparam bit DST_CHECK = 1'b0;
`else
    localparam bit DST_CHECK = 1'b1;
`endif

    localparam logic [15:0] TMO_CYCLES = 16'(STATUS_TIMEOUT);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_match;
    logic        r_runt;
    logic        r_dvld_q;
    logic [47:0] r_src_sh;
    logic [15:0] r_type_sh;
    logic [13:0] r_len;
    logic        r_frame_valid;
    logic [47:0] r_src_addr;
    logic [15:0] r_eth_type;
    logic [13:0] r_payload_len;
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;
    logic [15:0] r_drop_cnt;
    logic        r_conf_rx_en;
    logic        r_conf_rx_jumbo_en;
    logic        r_conf_rx_no_chk_crc;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_match_nxt;
    logic        w_runt_nxt;
    logic [47:0] w_src_nxt;
    logic [15:0] w_type_nxt;
    logic [13:0] w_len_nxt;
    logic        w_close_rx;
    logic        w_start;
    logic        w_res;
    logic        w_res_runt;
    logic        w_res_force_bad;
    logic [2:0]  w_dst_idx;
    logic        w_dst_mis;
    logic [7:0]  w_type_exp;
    logic        w_stat_any;
    logic        w_accept;
    logic        w_inc_good;
    logic        w_inc_bad;
    logic        w_inc_drop;

    function automatic logic [7:0] dst_byte(input logic [2:0] idx);
        logic [47:0] s;
        s = MAC_LOCAL_ADDR << (8 * idx);
        return s[47:40];
    endfunction

    // The byte that opens a frame (from IDLE or WAIT_STATUS) is always destination byte 1.
    assign w_dst_idx  = (r_state == MAC_DST) ? r_cnt[2:0] : 3'd0;
    assign w_dst_mis  = DST_CHECK && (mac_rx_data != dst_byte(w_dst_idx));
    assign w_type_exp = (r_cnt == 16'd1) ? ETH_TYPE_FILTER[15:8] : ETH_TYPE_FILTER[7:0];
    assign w_stat_any = mac_rx_good_frame | mac_rx_bad_frame;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_match_nxt     = r_match;
        w_runt_nxt      = r_runt;
        w_src_nxt       = r_src_sh;
        w_type_nxt      = r_type_sh;
        w_len_nxt       = r_len;
        w_close_rx      = 1'b0;
        w_start         = 1'b0;
        w_res           = 1'b0;
        w_res_runt      = r_runt;
        w_res_force_bad = 1'b0;

        case (r_state)
            IDLE: begin
                if (mac_rx_dvld && !r_dvld_q) begin
                    w_start = 1'b1;
                end
            end
            MAC_DST: begin
                if (mac_rx_dvld) begin
                    if (w_dst_mis) begin
                        w_match_nxt = 1'b0;
                    end
                    if (r_cnt == 16'd5) begin
                        w_state_nxt = MAC_SRC;
                        w_cnt_nxt   = 16'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end else begin
                    w_close_rx = 1'b1;
                end
            end
            MAC_SRC: begin
                if (mac_rx_dvld) begin
                    w_src_nxt = {r_src_sh[39:0], mac_rx_data};
                    if (r_cnt == 16'd6) begin
                        w_state_nxt = ETH_TYPE;
                        w_cnt_nxt   = 16'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end else begin
                    w_close_rx = 1'b1;
                end
            end
            ETH_TYPE: begin
                if (mac_rx_dvld) begin
                    w_type_nxt = {r_type_sh[7:0], mac_rx_data};
                    if (mac_rx_data != w_type_exp) begin
                        w_match_nxt = 1'b0;
                    end
                    if (r_cnt == 16'd2) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = 16'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end else begin
                    w_close_rx = 1'b1;
                end
            end
            DATA: begin
                if (mac_rx_dvld) begin
                    if (r_len != 14'h3FFF) begin
                        w_len_nxt = r_len + 14'd1;
                    end
                end else begin
                    w_close_rx = 1'b1;
                end
            end
            WAIT_STATUS: begin
                if (w_stat_any) begin
                    w_res       = 1'b1;
                    w_state_nxt = IDLE;
                    w_start     = mac_rx_dvld;
                end else if (mac_rx_dvld) begin
                    w_res           = 1'b1;
                    w_res_force_bad = 1'b1;
                    w_start         = 1'b1;
                end else if (r_cnt >= TMO_CYCLES) begin
                    w_res           = 1'b1;
                    w_res_force_bad = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // dvld fell: a status pulse in this very cycle closes the frame immediately.
        if (w_close_rx) begin
            if (w_stat_any) begin
                w_res       = 1'b1;
                w_res_runt  = (r_state != DATA);
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = WAIT_STATUS;
                w_cnt_nxt   = 16'd1;
                w_runt_nxt  = (r_state != DATA);
            end
        end

        if (w_start) begin
            w_state_nxt = MAC_DST;
            w_cnt_nxt   = 16'd1;
            w_match_nxt = !w_dst_mis;
            w_runt_nxt  = 1'b0;
            w_len_nxt   = 14'd0;
        end
    end

    // A simultaneous good+bad pair, a timeout or a pre-empting new frame all count as bad.
    assign w_accept   = w_res && mac_rx_good_frame && !mac_rx_bad_frame && !w_res_force_bad
                        && r_match && !w_res_runt;
    assign w_inc_good = w_accept;
    assign w_inc_bad  = w_res && (mac_rx_bad_frame || w_res_force_bad);
    assign w_inc_drop = w_res && !w_inc_bad && !w_accept;

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_state              <= IDLE;
            r_cnt                <= 16'd0;
            r_match              <= 1'b0;
            r_runt               <= 1'b0;
            r_dvld_q             <= mac_rx_dvld;
            r_src_sh             <= 48'd0;
            r_type_sh            <= 16'd0;
            r_len                <= 14'd0;
            r_frame_valid        <= 1'b0;
            r_src_addr           <= 48'd0;
            r_eth_type           <= 16'd0;
            r_payload_len        <= 14'd0;
            r_good_cnt           <= 16'd0;
            r_bad_cnt            <= 16'd0;
            r_drop_cnt           <= 16'd0;
            r_conf_rx_en         <= 1'b0;
            r_conf_rx_jumbo_en   <= 1'b0;
            r_conf_rx_no_chk_crc <= 1'b0;
        end else begin
            r_state              <= w_state_nxt;
            r_cnt                <= w_cnt_nxt;
            r_match              <= w_match_nxt;
            r_runt               <= w_runt_nxt;
            r_dvld_q             <= mac_rx_dvld;
            r_src_sh             <= w_src_nxt;
            r_type_sh            <= w_type_nxt;
            r_len                <= w_len_nxt;
            r_frame_valid        <= w_accept;
            r_conf_rx_en         <= 1'b1;
            r_conf_rx_jumbo_en   <= 1'b0;
            r_conf_rx_no_chk_crc <= 1'b0;
            if (w_accept) begin
                r_src_addr    <= r_src_sh;
                r_eth_type    <= r_type_sh;
                r_payload_len <= r_len;
            end
            if (w_inc_good && r_good_cnt != 16'hFFFF) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_inc_bad && r_bad_cnt != 16'hFFFF) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
            if (w_inc_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign conf_rx_en         = r_conf_rx_en;
    assign conf_rx_jumbo_en   = r_conf_rx_jumbo_en;
    assign conf_rx_no_chk_crc = r_conf_rx_no_chk_crc;
    assign frame_valid        = r_frame_valid;
    assign rx_src_addr        = r_src_addr;
    assign rx_eth_type        = r_eth_type;
    assign rx_payload_len     = r_payload_len;
    assign good_count         = r_good_cnt;
    assign bad_count          = r_bad_cnt;
    assign drop_count         = r_drop_cnt;

endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver: accepted frames queued at stimulus time, popped on frame_valid.
module tb_frame_receiver;

    localparam logic [47:0] LOCAL = 48'h004e46324301;
    localparam int O_ACC  = 0;
    localparam int O_DROP = 1;
    localparam int O_BAD  = 2;
    localparam int K_NONE = 0;
    localparam int K_GOOD = 1;
    localparam int K_BAD  = 2;
    localparam int K_BOTH = 3;

    logic        rx_clk = 1'b0;
    logic        reset;
    logic        conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_dvld, mac_rx_good_frame, mac_rx_bad_frame;
    logic        frame_valid;
    logic [47:0] rx_src_addr;
    logic [15:0] rx_eth_type;
    logic [13:0] rx_payload_len;
    logic [15:0] good_count, bad_count, drop_count;

    frame_receiver dut (
        .rx_clk             (rx_clk),
        .reset              (reset),
        .conf_rx_en         (conf_rx_en),
        .conf_rx_jumbo_en   (conf_rx_jumbo_en),
        .conf_rx_no_chk_crc (conf_rx_no_chk_crc),
        .mac_rx_data        (mac_rx_data),
        .mac_rx_dvld        (mac_rx_dvld),
        .mac_rx_good_frame  (mac_rx_good_frame),
        .mac_rx_bad_frame   (mac_rx_bad_frame),
        .frame_valid        (frame_valid),
        .rx_src_addr        (rx_src_addr),
        .rx_eth_type        (rx_eth_type),
        .rx_payload_len     (rx_payload_len),
        .good_count         (good_count),
        .bad_count          (bad_count),
        .drop_count         (drop_count)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        logic [47:0] src;
        logic [15:0] typ;
        logic [13:0] len;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_good = 16'd0, m_bad = 16'd0, m_drop = 16'd0;
    logic [47:0] last_src = 48'd0;
    logic [15:0] last_typ = 16'd0;
    logic [13:0] last_len = 14'd0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge rx_clk) begin
        if (!reset && frame_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_frame_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_src", rx_src_addr, e.src);
                chk("sb_type", rx_eth_type, e.typ);
                chk("sb_len", rx_payload_len, e.len);
                last_src = e.src;
                last_typ = e.typ;
                last_len = e.len;
            end
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic expect_outcome(input int o, input logic [47:0] src, input logic [15:0] typ,
                                  input int plen);
        exp_t e;
        if (o == O_ACC) begin
            e.src = src;
            e.typ = typ;
            e.len = (plen > 16383) ? 14'h3FFF : 14'(plen);
            sb_q.push_back(e);
            m_good = sat_inc(m_good);
        end else if (o == O_DROP) begin
            m_drop = sat_inc(m_drop);
        end else begin
            m_bad = sat_inc(m_bad);
        end
    endtask

    // Drives one frame; returns in the cycle where dvld has just dropped.
    task automatic frame_bytes(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                               input int plen, input int nbytes, input int rst_at);
        int total;
        logic [7:0] b;
        total = (nbytes < 0) ? 14 + plen : nbytes;
        @(posedge rx_clk); #1;
        for (int i = 0; i < total; i++) begin
            if (i < 6)       b = 8'(dst >> (40 - 8 * i));
            else if (i < 12) b = 8'(src >> (40 - 8 * (i - 6)));
            else if (i < 14) b = 8'(typ >> (8 - 8 * (i - 12)));
            else             b = 8'(i);
            mac_rx_data = b;
            mac_rx_dvld = 1'b1;
            if (rst_at >= 0 && i == rst_at)     reset = 1'b1;
            if (rst_at >= 0 && i == rst_at + 2) reset = 1'b0;
            @(posedge rx_clk); #1;
        end
        mac_rx_dvld = 1'b0;
        mac_rx_data = 8'd0;
    endtask

    task automatic status(input int kind, input int delay);
        repeat (delay) begin
            @(posedge rx_clk); #1;
        end
        if (kind != K_NONE) begin
            mac_rx_good_frame = (kind == K_GOOD) || (kind == K_BOTH);
            mac_rx_bad_frame  = (kind == K_BAD) || (kind == K_BOTH);
            @(posedge rx_clk); #1;
            mac_rx_good_frame = 1'b0;
            mac_rx_bad_frame  = 1'b0;
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_good"}, good_count, m_good);
        chk({tag, "_bad"}, bad_count, m_bad);
        chk({tag, "_drop"}, drop_count, m_drop);
    endtask

    task automatic finish_frame(input string tag, input logic exp_fv);
        @(negedge rx_clk);
        chk({tag, "_fv"}, frame_valid, exp_fv);
        @(negedge rx_clk);
        chk({tag, "_fv_1cyc"}, frame_valid, 1'b0);
        check_counts(tag);
    endtask

    task automatic run_frame(input string tag, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int plen, input int nbytes,
                             input int kind, input int delay, input int o);
        expect_outcome(o, src, typ, plen);
        frame_bytes(dst, src, typ, plen, nbytes, -1);
        status(kind, delay);
        finish_frame(tag, o == O_ACC);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mac_rx_data = 8'd0;
        mac_rx_dvld = 1'b0;
        mac_rx_good_frame = 1'b0;
        mac_rx_bad_frame = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        chk("rst_conf_en", conf_rx_en, 1'b0);
        chk("rst_src", rx_src_addr, 48'd0);
        chk("rst_fv", frame_valid, 1'b0);
        check_counts("rst");
        @(posedge rx_clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge rx_clk);
        chk("conf_en", conf_rx_en, 1'b1);
        chk("conf_jumbo", conf_rx_jumbo_en, 1'b0);
        chk("conf_nochk", conf_rx_no_chk_crc, 1'b0);

        run_frame("basic", LOCAL, 48'h004e46324300, 16'h0800, 46, -1, K_GOOD, 2, O_ACC);
        chk("basic_src", rx_src_addr, 48'h004e46324300);
        chk("basic_len", rx_payload_len, 14'd46);

`ifdef FRAME_RECEIVER_PROMISC_EN
        run_frame("dst_miss", 48'h004e46324399, 48'h004e46324300, 16'h0800, 46, -1, K_GOOD, 2, O_ACC);
`else
        run_frame("dst_miss", 48'h004e46324399, 48'h004e46324300, 16'h0800, 46, -1, K_GOOD, 2, O_DROP);
`endif

        run_frame("arp_bad", LOCAL, 48'h0a0b0c0d0e0f, 16'h0806, 30, -1, K_BAD, 1, O_BAD);
        chk("hold_src", rx_src_addr, last_src);
        chk("hold_type", rx_eth_type, last_typ);
        chk("hold_len", rx_payload_len, last_len);
        run_frame("arp_good", LOCAL, 48'h0a0b0c0d0e0f, 16'h0806, 30, -1, K_GOOD, 1, O_DROP);

        run_frame("runt10", LOCAL, 48'h111111111111, 16'h0800, 0, 10, K_GOOD, 1, O_DROP);
        run_frame("runt13", LOCAL, 48'h111111111111, 16'h0800, 0, 13, K_GOOD, 1, O_DROP);
        run_frame("hdr_only", LOCAL, 48'h222222222222, 16'h0800, 0, -1, K_GOOD, 1, O_ACC);
        run_frame("same_cyc", LOCAL, 48'h333333333333, 16'h0800, 7, -1, K_GOOD, 0, O_ACC);
        run_frame("both", LOCAL, 48'h444444444444, 16'h0800, 9, -1, K_BOTH, 1, O_BAD);
        run_frame("late16", LOCAL, 48'h555555555555, 16'h0800, 5, -1, K_GOOD, 16, O_ACC);

        // No status: timeout closes as bad, and a later stray status is ignored in IDLE.
        expect_outcome(O_BAD, 48'd0, 16'd0, 0);
        frame_bytes(LOCAL, 48'h666666666666, 16'h0800, 12, -1, -1);
        repeat (20) @(posedge rx_clk);
        #1;
        status(K_GOOD, 0);
        finish_frame("timeout", 1'b0);

        // Second frame arrives before status of the first.
        expect_outcome(O_BAD, 48'd0, 16'd0, 0);
        frame_bytes(LOCAL, 48'h777777777777, 16'h0800, 20, -1, -1);
        expect_outcome(O_ACC, 48'h112233445566, 16'h0800, 50);
        frame_bytes(LOCAL, 48'h112233445566, 16'h0800, 50, -1, -1);
        status(K_GOOD, 1);
        finish_frame("b2b", 1'b1);

        run_frame("len_sat", LOCAL, 48'h0123456789ab, 16'h0800, 16400, -1, K_GOOD, 1, O_ACC);

        // Reset at DATA byte 20; rest of that frame and its status must be ignored.
        frame_bytes(LOCAL, 48'h888888888888, 16'h0800, 40, -1, 33);
        m_good = 16'd0; m_bad = 16'd0; m_drop = 16'd0;
        last_src = 48'd0; last_typ = 16'd0; last_len = 14'd0;
        status(K_GOOD, 2);
        finish_frame("mid_rst", 1'b0);
        chk("mid_rst_src", rx_src_addr, 48'd0);
        chk("mid_rst_len", rx_payload_len, 14'd0);
        run_frame("post_rst", LOCAL, 48'h999999999999, 16'h0800, 46, -1, K_GOOD, 2, O_ACC);

        @(negedge rx_clk);
        force dut.r_good_cnt = 16'hFFFF;
        @(negedge rx_clk);
        release dut.r_good_cnt;
        m_good = 16'hFFFF;
        @(negedge rx_clk);
        chk("forced_good", good_count, 16'hFFFF);
        run_frame("good_sat", LOCAL, 48'haaaaaaaaaaaa, 16'h0800, 46, -1, K_GOOD, 2, O_ACC);

        repeat (3) @(negedge rx_clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have parameter MAC_LOCAL_ADDR, default 48'h004e46324301: station address for destination match.
REQ-002 SHALL have parameter ETH_TYPE_FILTER, default 16'h0800: required EtherType.
REQ-003 SHALL have parameter STATUS_TIMEOUT, default 16: maximum cycles from end of frame to MAC status.
REQ-004 SHALL have one clock and a synchronous, active-high reset: rx_clk (input, 1), rising-edge clock; reset (input, 1), synchronous active-high reset.
REQ-005 SHALL have conf_rx_en (output, 1): receive enable to MAC.
REQ-006 SHALL have conf_rx_jumbo_en (output, 1): jumbo enable to MAC.
REQ-007 SHALL have conf_rx_no_chk_crc (output, 1): CRC-check bypass to MAC.
REQ-008 SHALL have mac_rx_data (input, 8): received byte, MSB-first field order.
REQ-009 SHALL have mac_rx_dvld (input, 1): byte valid; high for a contiguous frame.
REQ-010 SHALL have mac_rx_good_frame and mac_rx_bad_frame (input, 1 each): one-cycle frame status pulses.
REQ-011 SHALL have frame_valid (output, 1): one-cycle pulse when an accepted frame completes.
REQ-012 SHALL have rx_src_addr (output, 48), rx_eth_type (output, 16) and rx_payload_len (output, 14): fields of the last accepted frame.
REQ-013 SHALL have good_count, bad_count and drop_count (output, 16 each): saturating statistics counters.

Function
REQ-014 SHALL drive conf_rx_en=1, conf_rx_jumbo_en=0 and conf_rx_no_chk_crc=0 from registers once out of reset.
REQ-015 SHALL implement the states IDLE, MAC_DST, MAC_SRC, ETH_TYPE, DATA, WAIT_STATUS.
REQ-016 SHALL use a byte counter that restarts at 1 on every state change.
REQ-017 SHALL go IDLE->MAC_DST on mac_rx_dvld=1, with that byte being destination byte 1.
REQ-018 SHALL leave MAC_DST, MAC_SRC and ETH_TYPE after 6, 6 and 2 bytes respectively, into the next state.
REQ-019 SHALL clear a per-frame match flag if any destination byte differs from MAC_LOCAL_ADDR, or if the EtherType differs from ETH_TYPE_FILTER.
REQ-020 SHALL shift source-address and EtherType bytes into shadow registers, not into the outputs.
REQ-021 SHALL count each DATA byte in a 14-bit length counter that saturates at 16383.
REQ-022 SHALL go from any receive state to WAIT_STATUS when mac_rx_dvld falls.
REQ-023 SHALL accept a status pulse on the same cycle mac_rx_dvld falls.
REQ-024 SHALL treat a frame that ends before 14 header bytes as a runt.
REQ-025 SHALL, in WAIT_STATUS on good status with match set and no runt: assert frame_valid for 1 cycle; copy the shadows and length to the outputs on that same cycle; increment good_count; return to IDLE.
REQ-026 SHALL, on good status with match clear or a runt: increment drop_count, with no frame_valid.
REQ-027 SHALL, on bad status: increment bad_count only.
REQ-028 SHALL treat both status pulses in the same cycle as bad.
REQ-029 SHALL treat STATUS_TIMEOUT cycles with no status as bad.
REQ-030 SHALL, if mac_rx_dvld=1 in WAIT_STATUS with no status, close the pending frame as bad and take the byte as destination byte 1 of a new frame in the same cycle.
REQ-031 SHALL hold rx_src_addr, rx_eth_type and rx_payload_len unchanged between frame_valid pulses.
REQ-032 SHALL saturate all counters at 16'hFFFF, with no wrap.
REQ-033 SHALL have frame_valid latency = 1 cycle after the status cycle.

Reset
REQ-034 SHALL, on reset, set the state to IDLE, the counter to 0, all statistics to 0, the outputs rx_* to 0, frame_valid=0 and conf_rx_*=0.
REQ-035 SHALL, on reset mid-frame, discard the frame with no counter update; the next byte after reset that starts a frame when mac_rx_dvld rises is parsed as destination byte 1.

Configuration
REQ-036 SHALL, with macro FRAME_RECEIVER_PROMISC_EN defined, skip the destination-address comparison, so any destination is accepted and only the EtherType filter applies.
REQ-037 SHALL, without FRAME_RECEIVER_PROMISC_EN, apply the destination comparison of REQ-019.

Verification
REQ-038 SHALL verify: frame dst 004e46324301, src 004e46324300, type 0800, 46 payload bytes, then good -> frame_valid 1 cycle, rx_src_addr=48'h004e46324300, rx_eth_type=16'h0800, rx_payload_len=46, good_count=1.
REQ-039 SHALL verify: same frame with dst 004e46324399, good -> no frame_valid, drop_count=1; with PROMISC_EN defined -> frame_valid, good_count=1.
REQ-040 SHALL verify: valid frame with type 0806, then bad -> bad_count=1; outputs retain the previous frame's values.
REQ-041 SHALL verify: 10-byte runt, then good -> drop_count=1; separately, a valid frame with no status for 16 cycles -> bad_count=1, state IDLE.
REQ-042 SHALL verify: new dvld in WAIT_STATUS before status -> bad_count+1 and the second frame is parsed correctly (frame_valid on its good status).
REQ-043 SHALL verify: reset asserted at DATA byte 20 -> all counters 0; the next valid frame is accepted normally; forcing good_count=16'hFFFF then one more good frame -> remains 16'hFFFF.
